// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequenced shift-add multiplier controller:
// state codes, operand width and status-word field positions.
package mul_seq_ctrl_pkg;

  localparam int MUL_W = 4;
  localparam int OPS_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD_B = 2'b01,
    ST_RUN    = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam int STAT_STATE_LSB = 6;
  localparam int STAT_STEP_LSB  = 4;
  localparam int STAT_VALID_BIT = 3;
  localparam int STAT_OPS_LSB   = 0;

  function automatic logic [7:0] pack_status(input state_t st, input logic [1:0] step,
                                             input logic valid, input logic [OPS_W-1:0] ops);
    logic [7:0] w;
    w = '0;
    w[STAT_STATE_LSB +: 2]     = st;
    w[STAT_STEP_LSB +: 2]      = step;
    w[STAT_VALID_BIT]          = valid;
    w[STAT_OPS_LSB +: OPS_W]   = ops;
    return w;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Tile harness pins: 8 inputs (clock, reset, start, view, data nibble) and 8 outputs.
interface mul_seq_ctrl_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/mul_shift_add_step.sv
// One shift-add iteration: adds A shifted by the step index when the selected B bit is set.
module mul_shift_add_step #(
  parameter int W  = 4,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]   a,
  input  logic           b_bit,
  input  logic [SW-1:0]  step,
  input  logic [2*W-1:0] acc,
  output logic [2*W-1:0] acc_next
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] partial;

  always_comb begin
    a_ext    = {{W{1'b0}}, a};
    partial  = b_bit ? (a_ext << step) : '0;
    acc_next = acc + partial;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequenced multiplier controller: operands arrive over the nibble bus on consecutive
// edges, W shift-add steps follow, and the product or a status word is muxed to io_out.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int W = MUL_W
) (
  mul_seq_ctrl_if.slave bus
);

  localparam int SW = $clog2(W);

  logic         clk;
  logic         rst;
  logic         start;
  logic         view;
  logic [W-1:0] data;

  assign clk   = bus.io_in[0];
  assign rst   = bus.io_in[1];
  assign start = bus.io_in[2];
  assign view  = bus.io_in[3];
  assign data  = bus.io_in[4 +: W];

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   product_q;
  logic [SW-1:0]    step_q;
  logic             valid_q;
  logic [OPS_W-1:0] ops_q;
  logic [2*W-1:0]   acc_next;

  mul_shift_add_step #(.W(W), .SW(SW)) u_step (
    .a        (a_q),
    .b_bit    (b_q[step_q]),
    .step     (step_q),
    .acc      (acc_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      step_q    <= '0;
      valid_q   <= 1'b0;
      ops_q     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q   <= data;
            state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          b_q    <= data;
          acc_q  <= '0;
          step_q <= '0;
          state  <= ST_RUN;
        end
        ST_RUN: begin
          acc_q <= acc_next;
          // step returns to 0 on completion so the status word reads 0 outside RUN
          if (step_q == SW'(W - 1)) begin
            product_q <= acc_next;
            valid_q   <= 1'b1;
            ops_q     <= ops_q + 1'b1;
            step_q    <= '0;
            state     <= ST_DONE;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [7:0] status;

  always_comb begin
    status     = pack_status(state, step_q, valid_q, ops_q);
    bus.io_out = view ? status : product_q;
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: scoreboard of expected products/op counts.
module tb_mul_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       view;
  logic [3:0] data;

  mul_seq_ctrl_if bus ();
  assign bus.io_in = {data, view, start, rst, clk};

  mul_seq_ctrl dut (.bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] prod;
    logic [2:0] ops;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_ops = 3'd0;
  logic [7:0] last_product = 8'd0;

  task automatic read_both(output logic [7:0] st, output logic [7:0] pr);
    view = 1'b1; #1 st = bus.io_out;
    view = 1'b0; #1 pr = bus.io_out;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input bit hold, input logic [3:0] hold_data);
    exp_t       e;
    exp_t       got;
    logic [7:0] st;
    logic [7:0] pr;
    logic [7:0] pa;
    int         n;
    bit         done;
    pa     = {4'b0, a};
    e.prod = pa * {4'b0, b};
    e.ops  = exp_ops + 3'd1;
    sb.push_back(e);
    start = 1'b1;
    data  = a;
    @(posedge clk);
    n = 1;
    done = 1'b0;
    st = '0;
    pr = '0;
    while (!done && n <= 12) begin
      @(negedge clk);
      read_both(st, pr);
      if (st[7:6] == 2'b11) begin
        done = 1'b1;
      end else begin
        total++;
        if (pr !== last_product) begin
          bad++;
          $display("FAIL product_hold a=%0d b=%0d edge=%0d got=%0d want=%0d", a, b, n, pr, last_product);
        end
        if (n == 1) begin
          data  = b;
          start = hold;
        end else if (hold) begin
          data = hold_data;
        end
        @(posedge clk);
        n++;
      end
    end
    start = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL op_timeout a=%0d b=%0d got=no_done want=done", a, b);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      if (n !== 6) begin
        bad++;
        $display("FAIL latency a=%0d b=%0d got=%0d want=6", a, b, n);
      end
      total++;
      if (pr !== got.prod) begin
        bad++;
        $display("FAIL product a=%0d b=%0d got=%0d want=%0d", a, b, pr, got.prod);
      end
      total++;
      if (st !== {2'b11, 2'b00, 1'b1, got.ops}) begin
        bad++;
        $display("FAIL status a=%0d b=%0d got=%h want=%h", a, b, st, {2'b11, 2'b00, 1'b1, got.ops});
      end
      last_product = got.prod;
      exp_ops      = got.ops;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ops      = 3'd0;
    last_product = 8'd0;
  endtask

  task automatic test_reset();
    logic [7:0] st;
    logic [7:0] pr;
    rst = 1'b1; start = 1'b0; view = 1'b0; data = 4'd0;
    repeat (2) @(negedge clk);
    read_both(st, pr);
    total++;
    if (st !== 8'h00) begin bad++; $display("FAIL reset_status got=%h want=00", st); end
    total++;
    if (pr !== 8'h00) begin bad++; $display("FAIL reset_product got=%h want=00", pr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_op(4'd3, 4'd7, 1'b0, 4'd0);
  endtask

  task automatic test_back_to_back();
    do_op(4'd15, 4'd15, 1'b0, 4'd0);
  endtask

  task automatic test_zero_operands();
    do_op(4'd0, 4'd9, 1'b0, 4'd0);
    do_op(4'd9, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic test_start_during_run();
    logic [7:0] st;
    logic [7:0] pr;
    do_op(4'd2, 4'd6, 1'b1, 4'd5);
    @(posedge clk);
    @(negedge clk);
    read_both(st, pr);
    total++;
    if (st !== {2'b11, 2'b00, 1'b1, exp_ops}) begin
      bad++;
      $display("FAIL no_extra_op got=%h want=%h", st, {2'b11, 2'b00, 1'b1, exp_ops});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] st;
    logic [7:0] pr;
    start = 1'b1; data = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; data = 4'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    read_both(st, pr);
    total++;
    if (st !== 8'h00) begin bad++; $display("FAIL midrun_reset_status got=%h want=00", st); end
    total++;
    if (pr !== 8'h00) begin bad++; $display("FAIL midrun_reset_product got=%h want=00", pr); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ops      = 3'd0;
    last_product = 8'd0;
    @(negedge clk);
    do_op(4'd4, 4'd4, 1'b0, 4'd0);
  endtask

  task automatic test_ops_wrap();
    logic [7:0] st;
    logic [7:0] pr;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 4'd0);
    end
    read_both(st, pr);
    total++;
    if (st[2:0] !== 3'd0) begin
      bad++;
      $display("FAIL ops_wrap got=%0d want=0", st[2:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_operands();
    test_start_during_run();
    test_reset_mid_run();
    test_ops_wrap();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
